// File: rtl/vga_timing_gen_if.sv
// Pixel-clock input and timing outputs of the VGA timing generator.
// The master modport is the generator; the slave modport is the renderer (or bench).
interface vga_timing_gen_if;
    logic       pix_in;
    logic       pix_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_in,
        output pix_tick, pix_x, pix_y, hsync, vsync, video_on, line_start, frame_start
    );

    modport slave (
        output pix_in,
        input  pix_tick, pix_x, pix_y, hsync, vsync, video_on, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: edge-detects the divided pixel clock into a tick and runs
// the raster counters, registering sync/blank/strobe outputs with zero skew to pix_x/pix_y.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              I_CLK,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds are 11 bit so a sync window ending exactly at 1024 cannot wrap.
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t     state, state_nxt;
    logic       pix_d;
    logic       tick;
    logic [9:0] x, y;
    logic [9:0] x_nxt, y_nxt;
    logic       line_nxt, frame_nxt;
    logic       hs_nxt, vs_nxt, vid_nxt;
    logic       pix_tick_q, hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    assign tick = vga.pix_in & ~pix_d;

    // State register.
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && tick) begin
            state_nxt = RUN;
        end
    end

    // Next raster position and strobes; the first tick only arms the counters at (0,0).
    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        x_nxt     = x;
        y_nxt     = y;
        line_nxt  = 1'b0;
        frame_nxt = 1'b0;
        if (tick) begin
            if (state == IDLE) begin
                x_nxt     = '0;
                y_nxt     = '0;
                line_nxt  = 1'b1;
                frame_nxt = 1'b1;
            end else if (x == H_LAST) begin
                x_nxt    = '0;
                line_nxt = 1'b1;
                if (y == V_LAST) begin
                    y_nxt     = '0;
                    frame_nxt = 1'b1;
                end else begin
                    y_nxt = y + 10'd1;
                end
            end else begin
                x_nxt = x + 10'd1;
            end
        end
    end

    // Level outputs decode the next position so they register on the counter edge.
    always_comb begin
        hs_nxt  = ({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END);
        vs_nxt  = ({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END);
        vid_nxt = (state_nxt == RUN) && ({1'b0, x_nxt} < H_VIS) && ({1'b0, y_nxt} < V_VIS);
    end

    // pix_d resets high so a pix_in already high at release is not seen as an edge.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            pix_d         <= 1'b1;
            x             <= '0;
            y             <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_d         <= vga.pix_in;
            x             <= x_nxt;
            y             <= y_nxt;
            pix_tick_q    <= tick;
            hsync_q       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            video_on_q    <= vid_nxt;
            line_start_q  <= line_nxt;
            frame_start_q <= frame_nxt;
        end
    end

    assign vga.pix_tick    = pix_tick_q;
    assign vga.pix_x       = x;
    assign vga.pix_y       = y;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule
